// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer and its note FIFO.
package melody_pkg;

    localparam int unsigned TUNE_W = 8;
    localparam int unsigned DUR_W  = 8;
    localparam int unsigned NOTE_W = 16;

    localparam logic [TUNE_W-1:0] TUNE_REST = 8'h00;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StPlay,
        StGap
    } state_e;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/melody_note_fifo.sv
// Synchronous note FIFO with show-ahead head, registered full/level and a flush input.
module melody_note_fifo
    import melody_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     RSTn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [NOTE_W-1:0]        wdata,
    input  logic                     pop,
    output logic [NOTE_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [NOTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic              full_q;
    logic              do_push, do_pop;

    // Full is the registered flag, so a same-cycle pop never frees room for a push.
    assign do_push = push && !full_q && !flush;
    assign do_pop  = pop && (level_q != '0) && !flush;

    always_comb begin
        level_d = level_q;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == LW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    assign head  = mem[rd_ptr_q];
    assign level = level_q;
    assign full  = full_q;

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: plays queued {tune, duration} notes with a beat prescaler and inter-note gap.
// Optional low-watermark irq port enabled by defining MELODY_LOWATER_IRQ_EN.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TICK_DIV = 500000,
    parameter int unsigned GAP_DIV  = 50000
`ifdef MELODY_LOWATER_IRQ_EN
    ,
    parameter int unsigned LOWATER  = 4
`endif
) (
    input  logic                   clk,
    input  logic                   RSTn,
    input  logic                   wr_en,
    input  logic [NOTE_W-1:0]      wr_data,
    input  logic                   start,
    input  logic                   stop,
    output logic [TUNE_W-1:0]      tune,
    output logic                   busy,
    output logic                   done,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf
`ifdef MELODY_LOWATER_IRQ_EN
    ,
    output logic                   irq
`endif
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = cnt_width(TICK_DIV);
    localparam int unsigned GW = cnt_width(GAP_DIV);

    state_e            state_q, state_d;
    logic [TUNE_W-1:0] tune_q, tune_d;
    logic [DUR_W-1:0]  beat_q, beat_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              pop;
    logic              has_next;
    logic [NOTE_W-1:0] head;
    logic [TUNE_W-1:0] head_tune;
    logic [DUR_W-1:0]  head_dur;

    melody_note_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .RSTn  (RSTn),
        .flush (stop),
        .push  (wr_en),
        .wdata (wr_data),
        .pop   (pop),
        .head  (head),
        .level (level),
        .full  (full)
    );

    assign head_tune = head[NOTE_W-1:DUR_W];
    assign head_dur  = head[DUR_W-1:0];
    assign has_next  = (level != '0);

    always_comb begin
        state_d = state_q;
        tune_d  = tune_q;
        beat_d  = beat_q;
        presc_d = presc_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        ovf_d   = ovf_q;
        if (start)          ovf_d = 1'b0;
        if (wr_en && full)  ovf_d = 1'b1;

        if (stop) begin
            state_d = StIdle;
            tune_d  = TUNE_REST;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && has_next) state_d = StLoad;
                end
                StLoad: begin
                    pop = 1'b1;
                    if (head_dur == '0) begin
                        tune_d  = TUNE_REST;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        tune_d  = head_tune;
                        beat_d  = head_dur;
                        presc_d = PW'(TICK_DIV - 1);
                        state_d = StPlay;
                    end
                end
                StPlay: begin
                    if (presc_q != '0) begin
                        presc_d = presc_q - 1'b1;
                    end else begin
                        presc_d = PW'(TICK_DIV - 1);
                        beat_d  = beat_q - 1'b1;
                        if (beat_q == DUR_W'(1)) begin
                            tune_d = TUNE_REST;
                            // The LOAD cycle itself is silent, so short gaps skip GAP.
                            if (GAP_DIV <= 1 && has_next) begin
                                state_d = StLoad;
                            end else if (GAP_DIV == 0) begin
                                done_d  = 1'b1;
                                state_d = StIdle;
                            end else begin
                                gap_d   = GW'(GAP_DIV - 1);
                                state_d = StGap;
                            end
                        end
                    end
                end
                StGap: begin
                    // Leave one cycle early when continuing so silence totals GAP_DIV.
                    if (gap_q == '0) begin
                        if (has_next) begin
                            state_d = StLoad;
                        end else begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end else if (gap_q == GW'(1) && has_next) begin
                        state_d = StLoad;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= StIdle;
            tune_q  <= TUNE_REST;
            beat_q  <= '0;
            presc_q <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tune_q  <= tune_d;
            beat_q  <= beat_d;
            presc_q <= presc_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tune = tune_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign ovf  = ovf_q;

`ifdef MELODY_LOWATER_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn)     irq_q <= 1'b0;
        else if (stop) irq_q <= 1'b0;
        else           irq_q <= busy && (level <= LW'(LOWATER));
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomized self-checking bench for melody_sequencer against a queue-based melody model.
module tb_melody_sequencer;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned GAP_DIV  = 2;
    localparam int unsigned LW       = $clog2(DEPTH) + 1;
`ifdef MELODY_LOWATER_IRQ_EN
    localparam int unsigned LOWATER  = 1;
`endif

    logic          clk = 1'b0;
    logic          RSTn = 1'b0;
    logic          wr_en = 1'b0;
    logic [15:0]   wr_data = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [7:0]    tune;
    logic          busy, done, full, ovf;
    logic [LW-1:0] level;
`ifdef MELODY_LOWATER_IRQ_EN
    logic          irq;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: queued notes and sticky overflow flag.
    logic [15:0] fifo_m[$];
    logic        ovf_m = 1'b0;

    always #5 clk = ~clk;

    melody_sequencer #(
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV),
        .GAP_DIV  (GAP_DIV)
`ifdef MELODY_LOWATER_IRQ_EN
        ,
        .LOWATER  (LOWATER)
`endif
    ) dut (
        .clk     (clk),
        .RSTn    (RSTn),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .start   (start),
        .stop    (stop),
        .tune    (tune),
        .busy    (busy),
        .done    (done),
        .full    (full),
        .level   (level),
        .ovf     (ovf)
`ifdef MELODY_LOWATER_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        if (fifo_m.size() == DEPTH) ovf_m = 1'b1;
        else                        fifo_m.push_back(d);
    endtask

    task automatic flush();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        fifo_m.delete();
        ovf_m = 1'b0;
        check_eq("flush_level", level, 0);
        check_eq("flush_ovf", ovf, 0);
        check_eq("flush_busy", busy, 0);
    endtask

    // Expected tune trace: each note for dur*TICK_DIV cycles, then GAP_DIV silent cycles;
    // a zero-duration entry or an empty queue ends playback with done where the next note
    // would have started.
    task automatic play(input int poke);
        int          exp_q[$];
        logic [15:0] n;
        exp_q = {};
        while (fifo_m.size() != 0) begin
            n = fifo_m.pop_front();
            if (n[7:0] == 8'd0) break;
            repeat (int'(n[7:0]) * TICK_DIV) exp_q.push_back(int'(n[15:8]));
            repeat (GAP_DIV) exp_q.push_back(0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        ovf_m = 1'b0;
        check_eq("load_busy", busy, 1);
        check_eq("load_tune", tune, 0);
        check_eq("start_ovf_clr", ovf, 0);
        tick();
        foreach (exp_q[i]) begin
            check_eq("tune", tune, exp_q[i]);
            check_eq("busy", busy, 1);
            check_eq("done_early", done, 0);
            start = (i == poke);
            tick();
        end
        start = 1'b0;
        check_eq("done", done, 1);
        check_eq("busy_fall", busy, 0);
        check_eq("tune_end", tune, 0);
        check_eq("level_end", level, fifo_m.size());
        tick();
        check_eq("done_pulse", done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        logic [7:0] t, d;

        repeat (2) tick();
        check_eq("rst_tune", tune, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_full", full, 0);
        RSTn = 1'b1;
        tick();

        // Two notes with underrun ending.
        push(16'h1103);
        push(16'h2102);
        play(-1);

        // End marker stops playback with an entry left behind.
        push(16'h1501);
        push(16'h0000);
        push(16'h1601);
        play(-1);
        flush();

        // Overflow: fifth write dropped.
        for (int i = 0; i < 5; i++) push({8'(8'h40 + i), 8'h01});
        check_eq("ovf_set", ovf, ovf_m);
        check_eq("ovf_level", level, fifo_m.size());
        check_eq("ovf_full", full, 1);
        play(3);

        // Stop during play: immediate silence, flush, no done.
        push(16'h3105);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check_eq("pre_stop_tune", tune, 8'h31);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        fifo_m.delete();
        check_eq("stop_tune", tune, 0);
        check_eq("stop_busy", busy, 0);
        check_eq("stop_level", level, 0);
        check_eq("stop_done", done, 0);
        tick();
        check_eq("stop_done2", done, 0);

        // Start on empty FIFO is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("empty_busy", busy, 0);
        check_eq("empty_tune", tune, 0);
        tick();
        check_eq("empty_busy2", busy, 0);

        // Write coinciding with stop is discarded.
        push(16'h5501);
        stop    = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'h5601;
        tick();
        stop  = 1'b0;
        wr_en = 1'b0;
        fifo_m.delete();
        check_eq("stop_wr_level", level, 0);

        // Randomized melodies, with occasional start pulses mid-play.
        for (int s = 0; s < 24; s++) begin
            cnt = $urandom_range(1, 5);
            for (int k = 0; k < cnt; k++) begin
                t = 8'($urandom_range(1, 255));
                d = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
                push({t, d});
            end
            check_eq("rnd_level", level, fifo_m.size());
            check_eq("rnd_full", full, fifo_m.size() == DEPTH);
            check_eq("rnd_ovf", ovf, ovf_m);
            play(int'($urandom_range(0, 40)));
            flush();
        end

`ifdef MELODY_LOWATER_IRQ_EN
        begin
            int n = 0;
            push(16'h6101);
            push(16'h6201);
            push(16'h6301);
            start = 1'b1;
            tick();
            start = 1'b0;
            check_eq("irq_low", irq, 0);
            while (level != 1 && n < 100) begin
                tick();
                n++;
            end
            check_eq("irq_wait_bound", n < 100, 1);
            check_eq("irq_lag", irq, 0);
            tick();
            check_eq("irq_rise", irq, 1);
            flush();
            check_eq("irq_stop_clr", irq, 0);
        end
`endif

        // Asynchronous reset mid-play.
        push(16'h4103);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check_eq("pre_rst_tune", tune, 8'h41);
        #2 RSTn = 1'b0;
        #1;
        fifo_m.delete();
        check_eq("arst_tune", tune, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_level", level, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_ovf", ovf, 0);
        #3 RSTn = 1'b1;
        tick();
        check_eq("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
